// File: rtl/code_converter_stream_if.sv
// code_converter_stream_if: request/response valid-ready bundle
// for the streaming code converter.
interface code_converter_stream_if #(
   parameter int DW = 12
);
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [2:0]    out_op;
   logic          out_err;

   modport master (
      output in_valid, in_op, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_op, out_err
   );

   modport slave (
      input  in_valid, in_op, in_data, out_ready,
      output in_ready, out_valid, out_data, out_op, out_err
   );
endinterface

// File: rtl/code_converter_stream.sv
// code_converter_stream: BIN/GRAY/BCD/EX3 converter on valid/ready
// streams. Optional macro CONV_ERR_COUNT_EN adds the err_count port.
module code_converter_stream #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   code_converter_stream_if.slave bus,
`ifdef CONV_ERR_COUNT_EN
   output logic [15:0]            err_count,
`endif
   output logic                   busy
);

   localparam int DW = (WIDTH > 4*DIGITS) ? WIDTH : 4*DIGITS;
   localparam int BD = (WIDTH + 2) / 3;
   localparam int ND = (BD > DIGITS) ? BD : DIGITS;
   localparam int BW = 4 * ND;
   localparam int DB = 4 * DIGITS;
   localparam int AW = WIDTH + 4;
   localparam int MC = (WIDTH > DIGITS) ? WIDTH : DIGITS;
   localparam int CW = $clog2(MC + 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      HOLD
   } state_e;

   typedef enum logic [2:0] {
      OP_B2G,
      OP_G2B,
      OP_B2BCD,
      OP_BCD2B,
      OP_BCD2E,
      OP_E2BCD,
      OP_B2E,
      OP_E2B
   } op_e;

   state_e          state_q, state_d;
   op_e             op_q, op_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic [DB-1:0]   dig_q, dig_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic            ovf_q, ovf_d;
   logic            derr_q, derr_d;
   logic [DW-1:0]   odata_q, odata_d;
   logic [2:0]      oop_q, oop_d;
   logic            oerr_q, oerr_d;

   logic [WIDTH-1:0] in_bin;
   logic [WIDTH-1:0] gray_enc;
   logic [WIDTH-1:0] gray_dec;
   logic [DB-1:0]   in_bcd;
   logic [DB-1:0]   e3_enc;
   logic [DB-1:0]   e3_dec;
   logic            e3_enc_err;
   logic            e3_dec_err;
   logic [BW-1:0]   dd_adj;
   logic [BW-1:0]   dd_nxt;
   logic            dd_ovf;
   logic [DB-1:0]   dd_lo;
   logic [DB-1:0]   dd_ex3;
   logic [3:0]      dg_raw;
   logic [3:0]      dg_val;
   logic            dg_bad;
   logic [AW-1:0]   acc_nxt;
   logic            acc_ovf;
   logic            is_dd;
   logic            unused_ok;

   assign in_bin   = bus.in_data[WIDTH-1:0];
   assign in_bcd   = bus.in_data[DB-1:0];
   assign gray_enc = in_bin ^ (in_bin >> 1);

   // each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      gray_dec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         gray_dec[i] = ^(in_bin >> i);
      end
   end

   always_comb begin
      e3_enc     = '0;
      e3_dec     = '0;
      e3_enc_err = 1'b0;
      e3_dec_err = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         e3_enc[4*k +: 4] = in_bcd[4*k +: 4] + 4'd3;
         e3_dec[4*k +: 4] = in_bcd[4*k +: 4] - 4'd3;
         if (in_bcd[4*k +: 4] > 4'd9) begin
            e3_enc_err = 1'b1;
         end
         if (in_bcd[4*k +: 4] < 4'd3 ||
             in_bcd[4*k +: 4] > 4'd12) begin
            e3_dec_err = 1'b1;
         end
      end
   end

   // the BCD register holds every digit the binary width can produce,
   // so digits above DIGITS flag an out-of-range value exactly
   always_comb begin
      dd_adj = bcd_q;
      for (int k = 0; k < ND; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            dd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
      dd_nxt = {dd_adj[BW-2:0], bin_q[WIDTH-1]};
      dd_ovf = 1'b0;
      for (int k = DIGITS; k < ND; k++) begin
         dd_ovf = dd_ovf | (|dd_nxt[4*k +: 4]);
      end
      dd_lo  = dd_nxt[DB-1:0];
      dd_ex3 = '0;
      for (int k = 0; k < DIGITS; k++) begin
         dd_ex3[4*k +: 4] = dd_lo[4*k +: 4] + 4'd3;
      end
   end

   assign dg_raw = dig_q[DB-1 -: 4];

   always_comb begin
      if (op_q == OP_E2B) begin
         dg_val = dg_raw - 4'd3;
         dg_bad = (dg_raw < 4'd3) || (dg_raw > 4'd12);
      end else begin
         dg_val = dg_raw;
         dg_bad = dg_raw > 4'd9;
      end
   end

   assign acc_nxt   = (acc_q << 3) + (acc_q << 1) + AW'(dg_val);
   assign acc_ovf   = |acc_nxt[AW-1:WIDTH];
   assign is_dd     = (op_q == OP_B2BCD) || (op_q == OP_B2E);
   assign unused_ok = dd_adj[BW-1];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      dig_d   = dig_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      derr_d  = derr_q;
      odata_d = odata_q;
      oop_d   = oop_q;
      oerr_d  = oerr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d   = op_e'(bus.in_op);
               oop_d  = bus.in_op;
               cnt_d  = '0;
               bin_d  = in_bin;
               bcd_d  = '0;
               dig_d  = in_bcd;
               acc_d  = '0;
               ovf_d  = 1'b0;
               derr_d = 1'b0;
               unique case (op_e'(bus.in_op))
                  OP_B2G: begin
                     odata_d = DW'(gray_enc);
                     oerr_d  = 1'b0;
                     state_d = HOLD;
                  end
                  OP_G2B: begin
                     odata_d = DW'(gray_dec);
                     oerr_d  = 1'b0;
                     state_d = HOLD;
                  end
                  OP_BCD2E: begin
                     odata_d = e3_enc_err ? '0 : DW'(e3_enc);
                     oerr_d  = e3_enc_err;
                     state_d = HOLD;
                  end
                  OP_E2BCD: begin
                     odata_d = e3_dec_err ? '0 : DW'(e3_dec);
                     oerr_d  = e3_dec_err;
                     state_d = HOLD;
                  end
                  default: begin
                     state_d = CONV;
                  end
               endcase
            end
         end
         CONV: begin
            cnt_d = cnt_q + 1'b1;
            if (is_dd) begin
               bin_d = bin_q << 1;
               bcd_d = dd_nxt;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  oerr_d  = dd_ovf;
                  odata_d = dd_ovf ? '0 :
                            (op_q == OP_B2E) ? DW'(dd_ex3) :
                                               DW'(dd_lo);
                  state_d = HOLD;
               end
            end else begin
               dig_d  = dig_q << 4;
               acc_d  = acc_nxt;
               ovf_d  = ovf_q | acc_ovf;
               derr_d = derr_q | dg_bad;
               if (cnt_q == CW'(DIGITS - 1)) begin
                  oerr_d  = ovf_d | derr_d;
                  odata_d = (ovf_d | derr_d) ? '0 :
                            DW'(acc_nxt[WIDTH-1:0]);
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_B2G;
         cnt_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         dig_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         derr_q  <= 1'b0;
         odata_q <= '0;
         oop_q   <= '0;
         oerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         dig_q   <= dig_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         derr_q  <= derr_d;
         odata_q <= odata_d;
         oop_q   <= oop_d;
         oerr_q  <= oerr_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = odata_q;
   assign bus.out_op    = oop_q;
   assign bus.out_err   = oerr_q;
   assign busy          = (state_q != IDLE);

`ifdef CONV_ERR_COUNT_EN
   logic [15:0] errc_q, errc_d;

   always_comb begin
      errc_d = errc_q;
      if ((state_q == HOLD) && bus.out_ready &&
          oerr_q && (errc_q != 16'hFFFF)) begin
         errc_d = errc_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         errc_q <= '0;
      end else begin
         errc_q <= errc_d;
      end
   end

   assign err_count = errc_q;
`endif

endmodule

// File: tb/tb_code_converter_stream.sv
// tb_code_converter_stream: directed and random requests checked
// against an arithmetic reference model (WIDTH=8, DIGITS=3).
module tb_code_converter_stream;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;
   localparam int DW     = 12;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   err_model = 0;
`ifdef CONV_ERR_COUNT_EN
   logic [15:0] err_count;
`endif

   code_converter_stream_if #(.DW(DW)) b();

   code_converter_stream #(
      .WIDTH (WIDTH),
      .DIGITS(DIGITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (b),
`ifdef CONV_ERR_COUNT_EN
      .err_count(err_count),
`endif
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference: plain integer arithmetic on decimal digits
   function automatic void model(input logic [2:0] op,
                                 input logic [11:0] d,
                                 output logic [11:0] r,
                                 output logic e);
      int v, g, acc, dg, p;
      r = '0;
      e = 1'b0;
      case (op)
         3'd0: begin
            v = int'(d[7:0]);
            r = 12'(v ^ (v >> 1));
         end
         3'd1: begin
            g = int'(d[7:0]);
            v = 0;
            for (int k = 0; k < WIDTH; k++) v = v ^ (g >> k);
            r = 12'(v);
         end
         3'd2, 3'd6: begin
            v = int'(d[7:0]);
            if (v >= 1000) e = 1'b1;
            p = 1;
            for (int k = 0; k < DIGITS; k++) begin
               dg = (v / p) % 10;
               if (op == 3'd6) dg = dg + 3;
               r = r | 12'(dg << (4*k));
               p = p * 10;
            end
         end
         3'd3, 3'd7: begin
            acc = 0;
            for (int k = DIGITS-1; k >= 0; k--) begin
               dg = int'(d[4*k +: 4]);
               if (op == 3'd7) begin
                  if (dg < 3 || dg > 12) e = 1'b1;
                  dg = dg - 3;
               end else if (dg > 9) begin
                  e = 1'b1;
               end
               acc = acc * 10 + dg;
            end
            if (acc > 255) e = 1'b1;
            r = 12'(acc);
         end
         3'd4, 3'd5: begin
            for (int k = 0; k < DIGITS; k++) begin
               dg = int'(d[4*k +: 4]);
               if (op == 3'd4) begin
                  if (dg > 9) e = 1'b1;
                  dg = dg + 3;
               end else begin
                  if (dg < 3 || dg > 12) e = 1'b1;
                  dg = dg - 3;
               end
               r = r | 12'((dg & 15) << (4*k));
            end
         end
         default: ;
      endcase
      if (e) r = '0;
   endfunction

   function automatic int lat_of(input logic [2:0] op);
      if (op == 3'd2 || op == 3'd6) return WIDTH + 1;
      if (op == 3'd3 || op == 3'd7) return DIGITS + 1;
      return 1;
   endfunction

   function automatic logic [11:0] gen_data(input logic [2:0] op);
      logic [11:0] d;
      int lo;
      d = 12'($urandom);
      if ((op == 3'd3 || op == 3'd4 || op == 3'd5 || op == 3'd7) &&
          $urandom_range(9, 0) < 7) begin
         lo = (op == 3'd5 || op == 3'd7) ? 3 : 0;
         for (int k = 0; k < DIGITS; k++)
            d[4*k +: 4] = 4'($urandom_range(lo + 9, lo));
      end
      return d;
   endfunction

   task automatic do_req(input logic [2:0]  op,
                         input logic [11:0] d,
                         input int          stall,
                         input bit          use_x,
                         input logic [11:0] xd,
                         input logic        xe);
      logic [11:0] exp_d;
      logic        exp_e;
      logic [11:0] held;
      int          lat;
      if (use_x) begin
         exp_d = xd;
         exp_e = xe;
      end else begin
         model(op, d, exp_d, exp_e);
      end
      @(negedge clk);
      b.in_valid = 1'b1;
      b.in_op    = op;
      b.in_data  = d;
      lat = 0;
      while (!b.in_ready && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("req_ready", 32'(b.in_ready), 32'd1);
      @(posedge clk);
      #1;
      b.in_valid = 1'b0;
      b.in_op    = 3'($urandom);
      b.in_data  = 12'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!b.out_valid && lat < 100);
      chk("latency", 32'(lat), 32'(lat_of(op)));
      chk("out_data", 32'(b.out_data), 32'(exp_d));
      chk("out_err", 32'(b.out_err), 32'(exp_e));
      chk("out_op", 32'(b.out_op), 32'(op));
      held = b.out_data;
      for (int i = 0; i < stall; i++) begin
         b.in_valid = 1'b1;
         b.in_op    = 3'($urandom);
         b.in_data  = 12'($urandom);
         @(negedge clk);
         chk("hold_valid", 32'(b.out_valid), 32'd1);
         chk("hold_data", 32'(b.out_data), 32'(held));
         chk("hold_ready", 32'(b.in_ready), 32'd0);
      end
      b.out_ready = 1'b1;
      @(posedge clk);
      #1;
      b.out_ready = 1'b0;
      b.in_valid  = 1'b0;
      if (exp_e && err_model < 65535) err_model++;
      @(negedge clk);
      chk("idle_ready", 32'(b.in_ready), 32'd1);
      chk("idle_valid", 32'(b.out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
`ifdef CONV_ERR_COUNT_EN
      chk("err_count", 32'(err_count), 32'(err_model));
`endif
   endtask

   initial begin
      logic [2:0] op;
      bit         seen;
      rst         = 1'b1;
      b.in_valid  = 1'b0;
      b.in_op     = '0;
      b.in_data   = '0;
      b.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(b.out_valid), 32'd0);
      chk("rst_data", 32'(b.out_data), 32'd0);
      chk("rst_op", 32'(b.out_op), 32'd0);
      chk("rst_err", 32'(b.out_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(b.in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", 32'(b.in_ready), 32'd1);

      do_req(3'd0, 12'h0A5, 5, 1'b1, 12'h0F7, 1'b0);
      do_req(3'd1, 12'h0F7, 0, 1'b1, 12'h0A5, 1'b0);
      do_req(3'd2, 12'h0FF, 1, 1'b1, 12'h255, 1'b0);
      do_req(3'd6, 12'h0FF, 0, 1'b1, 12'h588, 1'b0);
      do_req(3'd3, 12'h128, 0, 1'b1, 12'h080, 1'b0);
      do_req(3'd3, 12'h999, 2, 1'b1, 12'h000, 1'b1);
      do_req(3'd3, 12'h1A0, 0, 1'b1, 12'h000, 1'b1);
      do_req(3'd7, 12'h375, 0, 1'b1, 12'h02A, 1'b0);
      do_req(3'd5, 12'h375, 0, 1'b1, 12'h042, 1'b0);
      do_req(3'd5, 12'h3F5, 0, 1'b1, 12'h000, 1'b1);

      // abort a BIN2BCD request with reset in its fourth cycle
      @(negedge clk);
      chk("abort_ready", 32'(b.in_ready), 32'd1);
      b.in_valid = 1'b1;
      b.in_op    = 3'd2;
      b.in_data  = 12'h0FF;
      @(posedge clk);
      #1;
      b.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_rst_ready", 32'(b.in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_rel_ready", 32'(b.in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_data", 32'(b.out_data), 32'd0);
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (b.out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      do_req(3'd0, 12'h003, 0, 1'b1, 12'h002, 1'b0);

      for (int n = 0; n < 80; n++) begin
         op = 3'($urandom);
         do_req(op, gen_data(op), $urandom_range(3, 0),
                1'b0, 12'h000, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
